// File: rtl/ssd_ahb_arbiter.sv
// ssd_ahb_arbiter
// Two-requester arbiter that turns a granted request into a pair of AHB-Lite
// single writes: the latched payload to the SSD data register (BASE_ADDR),
// then 32'h1 to the done-flag register (BASE_ADDR + 4).
//
// Build option: define SSD_ARB_ROUND_ROBIN_EN for round-robin arbitration.
// Without it requester 0 always wins when both request.
//
// DATA_W must lie in 1..31 so the payload is zero-extended into hwdata.
//
// Requester handshake: req[i] is a level request. Once raised it stays high
// until the cycle in which ack[i] or err[i] is seen. ack/err are single-cycle
// one-hot pulses, never both in the same cycle. The payload is sampled only
// on the grant edge. Dropping req after the grant does not cancel the
// transfer. The cycle that carries ack/err is always spent in IDLE without a
// new grant, so a requester that is still holding req in that cycle is not
// granted twice for one request.
//
// dbg_state exposes the FSM state for checkers:
// 0 = IDLE, 1 = ADDR_DATA, 2 = ADDR_DONE, 3 = DATA_DONE.
module ssd_ahb_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int          DATA_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [DATA_W-1:0] req_data0,
    input  logic [DATA_W-1:0] req_data1,
    output logic [1:0]        ack,
    output logic [1:0]        err,
    output logic              busy,
    output logic              grant_id,
    output logic [31:0]       haddr,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic [1:0]        htrans,
    output logic              hmastlock,
    output logic [31:0]       hwdata,
    input  logic              hready,
    input  logic              hresp,
    output logic [1:0]        dbg_state
);

    localparam int          PAD_W        = 32 - DATA_W;
    localparam logic [1:0]  HTRANS_IDLE  = 2'b00;
    localparam logic [1:0]  HTRANS_NSEQ  = 2'b10;
    localparam logic [31:0] DONE_ADDR    = BASE_ADDR + 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ADDR_DATA = 2'd1,
        ST_ADDR_DONE = 2'd2,
        ST_DATA_DONE = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] payload_q;
    logic              winner;
    logic              grant_en;
    logic              ack_now;
    logic              err_now;

`ifdef SSD_ARB_ROUND_ROBIN_EN
    // Most recently granted requester; resets to 1 so requester 0 wins first.
    logic              rr_last_q;
`endif

    // A grant may only happen from IDLE, and never in the completion cycle.
    assign grant_en = (state_q == ST_IDLE) && (req != 2'b00) && (ack == 2'b00) && (err == 2'b00);

    // An error response seen while a data phase is outstanding ends the transfer.
    assign err_now = ((state_q == ST_ADDR_DONE) || (state_q == ST_DATA_DONE)) && hresp;

    // Clean completion of the done-flag data phase.
    assign ack_now = (state_q == ST_DATA_DONE) && hready && !hresp;

    // Pick the winning requester among the currently asserted request lines.
    always_comb begin
`ifdef SSD_ARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            winner = ~rr_last_q;
        end else begin
            winner = ~req[0];
        end
`else
        winner = ~req[0];
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: each bus phase advances on hready, errors fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    state_d = ST_ADDR_DATA;
                end
            end
            ST_ADDR_DATA: begin
                if (hready) begin
                    state_d = ST_ADDR_DONE;
                end
            end
            ST_ADDR_DONE: begin
                if (hresp) begin
                    state_d = ST_IDLE;
                end else if (hready) begin
                    state_d = ST_DATA_DONE;
                end
            end
            ST_DATA_DONE: begin
                if (hresp || hready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant bookkeeping: winner index and its payload are captured on the grant edge only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_id  <= 1'b0;
            payload_q <= '0;
        end else if (grant_en) begin
            grant_id  <= winner;
            payload_q <= winner ? req_data1 : req_data0;
        end
    end

`ifdef SSD_ARB_ROUND_ROBIN_EN
    // Round-robin pointer follows every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= 1'b1;
        end else if (grant_en) begin
            rr_last_q <= winner;
        end
    end
`endif

    // Single-cycle completion pulses, steered to the granted requester.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ack <= 2'b00;
            err <= 2'b00;
        end else begin
            ack <= 2'b00;
            err <= 2'b00;
            if (ack_now) begin
                ack[grant_id] <= 1'b1;
            end
            if (err_now) begin
                err[grant_id] <= 1'b1;
            end
        end
    end

    // Bus outputs decoded from the state alone, so reset clears them immediately.
    always_comb begin
        htrans = HTRANS_IDLE;
        haddr  = 32'h0;
        hwdata = 32'h0;
        hwrite = 1'b0;
        case (state_q)
            ST_ADDR_DATA: begin
                htrans = HTRANS_NSEQ;
                haddr  = BASE_ADDR;
                hwrite = 1'b1;
            end
            ST_ADDR_DONE: begin
                htrans = HTRANS_NSEQ;
                haddr  = DONE_ADDR;
                hwrite = 1'b1;
                hwdata = {{PAD_W{1'b0}}, payload_q};
            end
            ST_DATA_DONE: begin
                hwdata = 32'h1;
            end
            default: begin
                htrans = HTRANS_IDLE;
            end
        endcase
    end

    // Fixed transfer attributes: single 32-bit, non-locked, privileged data access.
    assign hsize     = 3'b010;
    assign hburst    = 3'b000;
    assign hprot     = 4'b0011;
    assign hmastlock = 1'b0;

    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ssd_ahb_arbiter.sv
`timescale 1ns/1ps
module tb_ssd_ahb_arbiter;

    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam logic [31:0] DONE = 32'hC000_0004;
    localparam int          DW   = 5;
`ifdef SSD_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [DW-1:0] req_data0, req_data1;
    logic [1:0]    ack, err;
    logic          busy, grant_id;
    logic [31:0]   haddr, hwdata;
    logic          hwrite, hmastlock;
    logic [2:0]    hsize, hburst;
    logic [3:0]    hprot;
    logic [1:0]    htrans;
    logic          hready, hresp;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    ssd_ahb_arbiter #(.BASE_ADDR(BASE), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data0(req_data0), .req_data1(req_data1),
        .ack(ack), .err(err), .busy(busy), .grant_id(grant_id),
        .haddr(haddr), .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .dbg_state(dbg_state)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- stimulus state ----------------
    logic [1:0]    req_nx = 2'b00;
    logic [DW-1:0] d0_nx = '0, d1_nx = '0;
    bit            rand_mode = 0;
    int            stall_pct = 0, err_pct = 0, stall_left = 0, err_tgt = 0;

    // ---------------- reference model / scoreboard ----------------
    bit          m_busy = 0, m_cool = 0;
    logic        m_w = 1'b0, m_last = 1'b1;
    logic [1:0]  exp_ack = 2'b00, exp_err = 2'b00;
    logic [63:0] exp_q[$];
    bit          pend_v = 0;
    logic [31:0] pend_addr = '0;
    logic [1:0]  ack_s = 2'b00, err_s = 2'b00;
    int          wr_cnt = 0;
    logic [31:0] first_wdata = '0;
    logic        prev_hready = 1'b1, prev_pend = 1'b0;
    logic [1:0]  prev_htrans = 2'b00;
    logic [31:0] prev_haddr = '0, prev_hwdata = '0;

    task automatic model_reset();
        m_busy = 0; m_cool = 0; m_w = 1'b0; m_last = 1'b1;
        exp_ack = 2'b00; exp_err = 2'b00; exp_q.delete();
        pend_v = 0; prev_hready = 1'b1; prev_pend = 1'b0; prev_htrans = 2'b00;
    endtask

    // Slave side: responds OKAY, optionally stalls or errors a data phase.
    task automatic slave_drive();
        hresp  = 1'b0;
        hready = 1'b1;
        if (pend_v && ((err_tgt == 1 && pend_addr == BASE) || (err_tgt == 2 && pend_addr == DONE))) begin
            hresp   = 1'b1;
            err_tgt = 0;
        end else if (stall_left > 0 && htrans == 2'b10 && haddr == DONE) begin
            hready = 1'b0;
            stall_left--;
        end else if (rand_mode) begin
            if (pend_v && $urandom_range(0, 99) < err_pct) hresp = 1'b1;
            else if ($urandom_range(0, 99) < stall_pct) hready = 1'b0;
        end
    endtask

    // Random requesters: hold until ack/err, then usually drop; rarely give up early.
    task automatic rand_requesters();
        for (int i = 0; i < 2; i++) begin
            if (req_nx[i]) begin
                if (ack_s[i] | err_s[i]) begin
                    if ($urandom_range(0, 99) < 70) req_nx[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 2) begin
                    req_nx[i] = 1'b0;
                end
            end else if ($urandom_range(0, 99) < 25) begin
                req_nx[i] = 1'b1;
            end
        end
        if ($urandom_range(0, 99) < 30) d0_nx = DW'($urandom_range(0, (1 << DW) - 1));
        if ($urandom_range(0, 99) < 30) d1_nx = DW'($urandom_range(0, (1 << DW) - 1));
    endtask

    // Checks the current cycle's outputs, then advances the model across the coming edge.
    task automatic monitor();
        bit   b0, cool_now;
        logic w;
        ack_s = ack;
        err_s = err;
        check("ack", ack, exp_ack);
        check("err", err, exp_err);
        check("ack_err_both", (|ack) && (|err), 0);
        check("busy", busy, m_busy);
        check("busy_vs_state", busy, dbg_state != 2'd0);
        check("grant_id", grant_id, m_w);
        check("bus_const", {hsize, hburst, hprot, hmastlock}, {3'b010, 3'b000, 4'b0011, 1'b0});
        if (!m_busy) begin
            check("idle_htrans", htrans, 2'b00);
            check("idle_haddr", haddr, 32'h0);
            check("idle_hwdata", hwdata, 32'h0);
        end
        if (m_busy && !prev_hready && prev_htrans == 2'b10)
            check("addr_stable", {htrans, haddr}, {prev_htrans, prev_haddr});
        if (m_busy && !prev_hready && prev_pend)
            check("wdata_stable", hwdata, prev_hwdata);

        b0 = m_busy;
        cool_now = m_cool;
        m_cool = 0;
        exp_ack = 2'b00;
        exp_err = 2'b00;
        if (hready && pend_v && !hresp) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wdata = hwdata;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL write_unexpected actual=%0h:%0h required=none", pend_addr, hwdata);
            end else begin
                check("write", {pend_addr, hwdata}, exp_q.pop_front());
            end
            if (b0 && pend_addr == DONE) begin
                exp_ack[m_w] = 1'b1; m_busy = 0; m_cool = 1;
            end
        end
        if (hready && pend_v && hresp && b0) begin
            exp_err[m_w] = 1'b1; m_busy = 0; m_cool = 1; exp_q.delete();
        end
        if (!b0 && !cool_now && req != 2'b00) begin
            if (req == 2'b01) w = 1'b0;
            else if (req == 2'b10) w = 1'b1;
            else w = RR ? ~m_last : 1'b0;
            m_w = w; m_last = w; m_busy = 1;
            exp_q.push_back({BASE, 32'(w ? req_data1 : req_data0)});
            exp_q.push_back({DONE, 32'h1});
        end
        prev_pend = pend_v;
        if (hready) begin
            pend_v = !hresp && htrans == 2'b10;
            pend_addr = haddr;
        end
        prev_hready = hready; prev_htrans = htrans; prev_haddr = haddr; prev_hwdata = hwdata;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_mode) rand_requesters();
        req = req_nx; req_data0 = d0_nx; req_data1 = d1_nx;
        slave_drive();
        @(negedge clk);
        monitor();
    endtask

    // Asserts reset at the current time (away from a rising edge) and checks reset values.
    task automatic apply_reset();
        reset = 1'b1;
        req_nx = 2'b00; req = 2'b00;
        model_reset();
        #1;
        check("rst_ack_err", {ack, err}, 4'b0000);
        check("rst_busy_gid", {busy, grant_id}, 2'b00);
        check("rst_htrans_hwrite", {htrans, hwrite}, 3'b000);
        check("rst_haddr", haddr, 32'h0);
        check("rst_hwdata", hwdata, 32'h0);
        repeat (2) begin
            @(negedge clk);
            check("rst_no_pulse", {ack, err}, 4'b0000);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [1:0]    req;
        logic [DW-1:0] d0, d1, d0_late;
        int            stall, err_tgt;
        logic [1:0]    exp_ack, exp_err;
        int            exp_lat, exp_wr;
        logic [31:0]   exp_wdata;
    } vec_t;

    function automatic vec_t mk(logic [1:0] r, logic [DW-1:0] d0, logic [DW-1:0] d1, logic [DW-1:0] d0l,
                                int st, int et, logic [1:0] ea, logic [1:0] ee, int lat, int wr,
                                logic [31:0] wd);
        vec_t v;
        v.req = r; v.d0 = d0; v.d1 = d1; v.d0_late = d0l; v.stall = st; v.err_tgt = et;
        v.exp_ack = ea; v.exp_err = ee; v.exp_lat = lat; v.exp_wr = wr; v.exp_wdata = wd;
        return v;
    endfunction

    vec_t vecs[8];
    int   order[$];
    int   lat;

    initial begin
        req = 2'b00; req_data0 = '0; req_data1 = '0; hready = 1'b1; hresp = 1'b0;
        //               req    d0  d1  late stall err  ack    err    lat wr wdata
        vecs[0] = mk(2'b01, 9,  0,  9,   0,    0,   2'b01, 2'b00, 4,  2, 32'd9);
        vecs[1] = mk(2'b10, 0,  22, 0,   0,    0,   2'b10, 2'b00, 4,  2, 32'd22);
        vecs[2] = mk(2'b11, 3,  7,  3,   0,    0,   2'b01, 2'b00, 4,  2, 32'd3);
        vecs[3] = mk(2'b01, 5,  0,  12,  0,    0,   2'b01, 2'b00, 4,  2, 32'd5);
        vecs[4] = mk(2'b10, 0,  17, 0,   2,    0,   2'b10, 2'b00, 6,  2, 32'd17);
        vecs[5] = mk(2'b01, 31, 0,  31,  0,    1,   2'b00, 2'b01, 3,  0, 32'd0);
        vecs[6] = mk(2'b10, 0,  1,  0,   0,    2,   2'b00, 2'b10, 4,  1, 32'd1);
        vecs[7] = mk(2'b01, 0,  0,  0,   0,    0,   2'b01, 2'b00, 4,  2, 32'd0);

        apply_reset();

        foreach (vecs[k]) begin
            req_nx = vecs[k].req; d0_nx = vecs[k].d0; d1_nx = vecs[k].d1;
            stall_left = vecs[k].stall; err_tgt = vecs[k].err_tgt; wr_cnt = 0;
            lat = -1;
            for (int c = 0; c < 40; c++) begin
                cycle();
                if (c == 0) d0_nx = vecs[k].d0_late;
                if ((ack_s | err_s) != 2'b00) begin
                    lat = c;
                    break;
                end
            end
            check($sformatf("vec%0d_ack", k), ack_s, vecs[k].exp_ack);
            check($sformatf("vec%0d_err", k), err_s, vecs[k].exp_err);
            check($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
            check($sformatf("vec%0d_writes", k), wr_cnt, vecs[k].exp_wr);
            if (vecs[k].exp_wr > 0) check($sformatf("vec%0d_wdata", k), first_wdata, vecs[k].exp_wdata);
            req_nx = 2'b00; err_tgt = 0; stall_left = 0;
            repeat (3) cycle();
        end

        // Both requesters held through three transfers, starting from reset.
        apply_reset();
        req_nx = 2'b11; d0_nx = 5'd3; d1_nx = 5'd7;
        for (int c = 0; c < 60 && order.size() < 3; c++) begin
            cycle();
            if (ack_s != 2'b00) order.push_back(ack_s == 2'b10 ? 1 : 0);
        end
        req_nx = 2'b00;
        check("hold_count", order.size(), 3);
        if (order.size() == 3) begin
            check("hold_order0", order[0], 0);
            check("hold_order1", order[1], RR ? 1 : 0);
            check("hold_order2", order[2], 0);
        end
        repeat (3) cycle();

        // Reset while the done-flag data phase is outstanding.
        req_nx = 2'b01; d0_nx = 5'd6;
        lat = -1;
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (pend_v && pend_addr == DONE) begin
                lat = c;
                break;
            end
        end
        check("reach_data_done", lat, 2);
        @(posedge clk);
        #1;
        hready = 1'b1; hresp = 1'b0;
        check("pre_reset_busy", busy, 1'b1);
        #2;
        apply_reset();
        repeat (3) cycle();

        // Randomized traffic against the model.
        rand_mode = 1; stall_pct = 20; err_pct = 5;
        repeat (3000) cycle();
        rand_mode = 0; req_nx = 2'b00; stall_pct = 0; err_pct = 0;
        for (int c = 0; c < 60 && m_busy; c++) cycle();
        repeat (3) cycle();
        check("drain_idle", m_busy, 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ssd_ahb_arbiter.md
SSD_AHB_ARBITER -- requirements
Module: ssd_ahb_arbiter

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hC000_0000, SSD data-register address; the done-flag register is at BASE_ADDR+4.
REQ-002 SHALL have parameter DATA_W, default 5, requester payload width; DATA_W SHALL be 1..31.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  async active-high reset
- req  in  2  per-requester write request, level, held until ack or err
- req_data0  in  DATA_W  requester 0 payload
- req_data1  in  DATA_W  requester 1 payload
- ack  out  2  one-cycle completion pulse, one-hot
- err  out  2  one-cycle error pulse, one-hot
- busy  out  1  high whenever state is not IDLE
- grant_id  out  1  index of the current/last granted requester
- haddr, hwrite, hsize, hburst, hprot, htrans, hmastlock, hwdata  out  32,1,3,3,4,2,1,32  AHB-Lite master outputs
- hready, hresp  in  1,1  AHB-Lite slave responses

Function
REQ-005 SHALL have four states: IDLE, ADDR_DATA, ADDR_DONE, DATA_DONE.
REQ-006 IDLE: if any req bit is high at a clock edge, SHALL latch the winner into grant_id and its payload into an internal register, then enter ADDR_DATA.
REQ-007 ADDR_DATA: SHALL drive haddr=BASE_ADDR, htrans=NONSEQ (2'b10), hwrite=1; on an edge with hready=1, SHALL enter ADDR_DONE.
REQ-008 ADDR_DONE: SHALL drive haddr=BASE_ADDR+4, htrans=NONSEQ, hwrite=1, and hwdata={zero-extend, latched payload}; on hready=1, SHALL enter DATA_DONE.
REQ-009 DATA_DONE: SHALL drive htrans=IDLE (2'b00) and hwdata=32'h1; on hready=1, SHALL pulse ack[grant_id] for one cycle and return to IDLE.
REQ-010 A completed transaction SHALL spend at least one IDLE cycle before the next grant; with zero wait states, req to ack SHALL take 4 cycles.
REQ-011 The bus SHALL always be driven with hsize=3'b010, hburst=3'b000, hprot=4'b0011, and hmastlock=0.
REQ-012 In IDLE, htrans SHALL be IDLE, and haddr and hwdata SHALL be 0.
REQ-013 The payload SHALL be sampled only at grant; changes to req_data after grant SHALL have no effect on the transfer.
REQ-014 If hresp=1 is seen at an edge in ADDR_DONE or DATA_DONE, SHALL:
- drive htrans=IDLE from the next cycle
- pulse err[grant_id] instead of ack
- return to IDLE
- cancel the pending done-flag address phase
REQ-015 Deassertion of req after grant SHALL NOT abort the transfer; ack or err SHALL still be issued.
REQ-016 ack and err SHALL never both be high, and at most one bit of each SHALL be high.

Reset
REQ-017 When reset is asserted, SHALL asynchronously set:
- state=IDLE
- ack=0, err=0, busy=0, grant_id=0
- htrans=IDLE, haddr=0, hwdata=0, hwrite=0
- round-robin pointer favouring requester 0
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer without issuing ack or err.

Configuration
REQ-019 With SSD_ARB_ROUND_ROBIN_EN defined, arbitration SHALL be round-robin: on simultaneous requests the requester not most recently granted wins.
REQ-020 Without SSD_ARB_ROUND_ROBIN_EN, arbitration SHALL be fixed priority, with requester 0 always winning.

Verification
REQ-021 req=2'b01, req_data0=5'd9, hready=1 -> AHB writes 0x9 to 0xC000_0000 and 0x1 to 0xC000_0004; ack=2'b01 on the 4th cycle after req.
REQ-022 req=2'b11 held through three transfers, payloads 3/7 -> with RR_EN the order is 0,1,0; without RR_EN the order is 0,0,0.
REQ-023 hready low for 2 cycles in ADDR_DONE -> haddr and hwdata stay stable; ack is delayed by exactly 2 cycles.
REQ-024 hresp=1 during the ADDR_DONE data phase -> err[grant_id] pulses, no done-flag write occurs, state returns to IDLE.
REQ-025 reset asserted while in DATA_DONE -> all outputs go to reset values immediately; no ack is issued.
REQ-026 req_data0 changed from 5 to 12 one cycle after grant -> hwdata carries 5.
